// File: rtl/mesi_cache_ctrl.sv
// mesi_cache_ctrl: tag/state controller for a set-associative, write-back,
// MESI-coherent last-level cache. Holds tag, MESI state and a tree-PLRU vector
// per set and serves one processor or snooped-bus request at a time.
//
// Optional feature macro: CACHE_STATS_EN (adds saturating stat_* counters).
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake; ready only while idle
//   req_op                 0 PrRd,1 PrWr,2 SnpRd,3 SnpWr,4 SnpRWIM,5 SnpInv,7 Clear
//   req_addr               byte address
//   req_snp_in             others' snoop result for our bus op (3 treated as HIT)
//   resp_valid             one-cycle response strobe
//   resp_hit/resp_way      hit flag, hit or victim way
//   resp_bus_op            0 none,1 READ,2 WRITE,3 INVALIDATE,4 RWIM
//   resp_snp_res           our snoop reply: 0 NOHIT,1 HIT,2 HITM
//   resp_wb/resp_wb_tag    dirty line written back and its tag
//   resp_state             final MESI state: 0 M,1 E,2 S,3 I
//   stat_rd/wr/hit/miss    (CACHE_STATS_EN only) processor-op counters
module mesi_cache_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned WAYS       = 16,
  parameter int unsigned SETS       = 16384
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  req_valid,
  output logic                                                  req_ready,
  input  logic [2:0]                                            req_op,
  input  logic [ADDR_W-1:0]                                     req_addr,
  input  logic [1:0]                                            req_snp_in,
  output logic                                                  resp_valid,
  output logic                                                  resp_hit,
  output logic [$clog2(WAYS)-1:0]                               resp_way,
  output logic [2:0]                                            resp_bus_op,
  output logic [1:0]                                            resp_snp_res,
  output logic                                                  resp_wb,
  output logic [ADDR_W-$clog2(LINE_BYTES)-$clog2(SETS)-1:0]     resp_wb_tag,
  output logic [1:0]                                            resp_state
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                                           stat_rd,
  output logic [31:0]                                           stat_wr,
  output logic [31:0]                                           stat_hit,
  output logic [31:0]                                           stat_miss
`endif
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned PLRU_W = WAYS - 1;
  localparam int unsigned LA_W   = TAG_W + IDX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_UPDATE = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;

  localparam logic [1:0] ST_M = 2'd0;
  localparam logic [1:0] ST_E = 2'd1;
  localparam logic [1:0] ST_S = 2'd2;
  localparam logic [1:0] ST_I = 2'd3;

  localparam logic [2:0] OP_PRRD    = 3'd0;
  localparam logic [2:0] OP_PRWR    = 3'd1;
  localparam logic [2:0] OP_SNPRD   = 3'd2;
  localparam logic [2:0] OP_SNPRWIM = 3'd4;
  localparam logic [2:0] OP_SNPINV  = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd7;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_READ = 3'd1;
  localparam logic [2:0] BUS_INV  = 3'd3;
  localparam logic [2:0] BUS_RWIM = 3'd4;

  localparam logic [1:0] SNP_NOHIT = 2'd0;
  localparam logic [1:0] SNP_HIT   = 2'd1;
  localparam logic [1:0] SNP_HITM  = 2'd2;

  // Storage
  logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
  logic [1:0]        st_q   [SETS][WAYS];
  logic [PLRU_W-1:0] plru_q [SETS];

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q;
  logic [LA_W-1:0]  addr_q;
  logic [1:0]       snp_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic             accept_c;

  logic [IDX_W-1:0] idx_c;
  logic [TAG_W-1:0] tag_c;
  logic             unused_addr_bits;

  assign idx_c            = addr_q[IDX_W-1:0];
  assign tag_c            = addr_q[LA_W-1:IDX_W];
  assign unused_addr_bits = ^req_addr[OFF_W-1:0];
  assign accept_c         = (state_q == S_IDLE) && req_valid && req_ready;

  // Registered decision, computed in LOOKUP and committed in UPDATE
  logic              d_hit, d_wb, d_wr_st, d_wr_tag, d_touch;
  logic [WAY_W-1:0]  d_way;
  logic [1:0]        d_st, d_snp;
  logic [2:0]        d_bus;
  logic [TAG_W-1:0]  d_wb_tag;
  logic [PLRU_W-1:0] d_plru;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_c) state_d = (req_op == OP_CLEAR) ? S_CLEAR : S_LOOKUP;
      S_LOOKUP: state_d = S_UPDATE;
      S_UPDATE: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      S_CLEAR:  if (clr_idx_q == IDX_W'(SETS - 1)) state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Tag match and lowest invalid way (descending loop so the lowest index wins)
  logic             hit_c, inv_found_c;
  logic [WAY_W-1:0] hit_way_c, inv_way_c;
  always_comb begin
    hit_c       = 1'b0;
    hit_way_c   = '0;
    inv_found_c = 1'b0;
    inv_way_c   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (st_q[idx_c][WAY_W'(w)] != ST_I && tag_q[idx_c][WAY_W'(w)] == tag_c) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
      if (st_q[idx_c][WAY_W'(w)] == ST_I) begin
        inv_found_c = 1'b1;
        inv_way_c   = WAY_W'(w);
      end
    end
  end

  // PLRU victim: at each node go away from the last-accessed side (1 = upper half)
  logic [PLRU_W-1:0] plru_cur_c;
  logic [WAY_W-1:0]  plru_vic_c;
  logic              vic_go_r;
  int                vic_node;
  assign plru_cur_c = plru_q[idx_c];
  always_comb begin
    plru_vic_c = '0;
    vic_go_r   = 1'b0;
    vic_node   = 0;
    for (int l = 0; l < WAY_W; l++) begin
      vic_go_r   = ~plru_cur_c[WAY_W'(vic_node)];
      plru_vic_c = (plru_vic_c << 1) | WAY_W'(vic_go_r);
      vic_node   = 2 * vic_node + 1 + int'(vic_go_r);
    end
  end

  // MESI decision for the captured request
  logic              wb_c, wr_st_c, wr_tag_c, touch_c;
  logic [WAY_W-1:0]  way_c, vic_way_c;
  logic [1:0]        cur_c, new_st_c, snp_c;
  logic [2:0]        bus_c;
  logic [TAG_W-1:0]  wb_tag_c;
  always_comb begin
    vic_way_c = inv_found_c ? inv_way_c : plru_vic_c;
    way_c     = hit_c ? hit_way_c : '0;
    cur_c     = hit_c ? st_q[idx_c][hit_way_c] : ST_I;
    new_st_c  = cur_c;
    bus_c     = BUS_NONE;
    snp_c     = SNP_NOHIT;
    wb_c      = 1'b0;
    wb_tag_c  = '0;
    wr_st_c   = 1'b0;
    wr_tag_c  = 1'b0;
    touch_c   = 1'b0;
    case (op_q)
      OP_PRRD, OP_PRWR: begin
        touch_c = 1'b1;
        wr_st_c = 1'b1;
        if (hit_c) begin
          if (op_q == OP_PRWR) begin
            new_st_c = ST_M;
            if (cur_c == ST_S) bus_c = BUS_INV;
          end
        end else begin
          way_c    = vic_way_c;
          wr_tag_c = 1'b1;
          wb_c     = (st_q[idx_c][vic_way_c] == ST_M);
          if (wb_c) wb_tag_c = tag_q[idx_c][vic_way_c];
          if (op_q == OP_PRRD) begin
            bus_c    = BUS_READ;
            new_st_c = (snp_q == SNP_NOHIT) ? ST_E : ST_S;
          end else begin
            bus_c    = BUS_RWIM;
            new_st_c = ST_M;
          end
        end
      end
      OP_SNPRD: begin
        if (hit_c) begin
          wr_st_c = 1'b1;
          if (cur_c == ST_M) begin
            new_st_c = ST_S;
            snp_c    = SNP_HITM;
            wb_c     = 1'b1;
            wb_tag_c = tag_q[idx_c][hit_way_c];
          end else begin
            new_st_c = ST_S;
            snp_c    = SNP_HIT;
          end
        end
      end
      OP_SNPRWIM: begin
        if (hit_c) begin
          wr_st_c  = 1'b1;
          new_st_c = ST_I;
          if (cur_c == ST_M) begin
            snp_c    = SNP_HITM;
            wb_c     = 1'b1;
            wb_tag_c = tag_q[idx_c][hit_way_c];
          end else begin
            snp_c = SNP_HIT;
          end
        end
      end
      OP_SNPINV: begin
        if (hit_c && cur_c == ST_S) begin
          wr_st_c  = 1'b1;
          new_st_c = ST_I;
          snp_c    = SNP_HIT;
        end
      end
      default: ;
    endcase
  end

  // PLRU update: mark every node on the path to way_c with the side taken
  logic [PLRU_W-1:0] plru_new_c;
  logic [WAY_W-1:0]  tch_sh;
  logic              tch_b;
  int                tch_node;
  always_comb begin
    plru_new_c = plru_cur_c;
    tch_sh     = way_c;
    tch_b      = 1'b0;
    tch_node   = 0;
    for (int l = 0; l < WAY_W; l++) begin
      tch_b                          = tch_sh[WAY_W-1];
      tch_sh                         = tch_sh << 1;
      plru_new_c[WAY_W'(tch_node)]   = tch_b;
      tch_node                       = 2 * tch_node + 1 + int'(tch_b);
    end
  end

`ifdef CACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  // Datapath, state/PLRU arrays and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_way     <= '0;
      resp_bus_op  <= '0;
      resp_snp_res <= '0;
      resp_wb      <= 1'b0;
      resp_wb_tag  <= '0;
      resp_state   <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      snp_q        <= '0;
      clr_idx_q    <= '0;
      d_hit        <= 1'b0;
      d_way        <= '0;
      d_st         <= '0;
      d_bus        <= '0;
      d_snp        <= '0;
      d_wb         <= 1'b0;
      d_wb_tag     <= '0;
      d_wr_st      <= 1'b0;
      d_wr_tag     <= 1'b0;
      d_touch      <= 1'b0;
      d_plru       <= '0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[IDX_W'(s)] <= '0;
        for (int w = 0; w < WAYS; w++) st_q[IDX_W'(s)][WAY_W'(w)] <= ST_I;
      end
`ifdef CACHE_STATS_EN
      stat_rd   <= '0;
      stat_wr   <= '0;
      stat_hit  <= '0;
      stat_miss <= '0;
`endif
    end else begin
      req_ready  <= (state_d == S_IDLE);
      resp_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            op_q      <= req_op;
            addr_q    <= req_addr[ADDR_W-1:OFF_W];
            snp_q     <= req_snp_in;
            clr_idx_q <= '0;
            if (req_op == OP_CLEAR) begin
              d_hit    <= 1'b0;
              d_way    <= '0;
              d_st     <= ST_I;
              d_bus    <= BUS_NONE;
              d_snp    <= SNP_NOHIT;
              d_wb     <= 1'b0;
              d_wb_tag <= '0;
`ifdef CACHE_STATS_EN
              stat_rd   <= '0;
              stat_wr   <= '0;
              stat_hit  <= '0;
              stat_miss <= '0;
`endif
            end
          end
        end
        S_LOOKUP: begin
          d_hit    <= hit_c;
          d_way    <= way_c;
          d_st     <= new_st_c;
          d_bus    <= bus_c;
          d_snp    <= snp_c;
          d_wb     <= wb_c;
          d_wb_tag <= wb_tag_c;
          d_wr_st  <= wr_st_c;
          d_wr_tag <= wr_tag_c;
          d_touch  <= touch_c;
          d_plru   <= plru_new_c;
`ifdef CACHE_STATS_EN
          if (op_q == OP_PRRD || op_q == OP_PRWR) begin
            if (op_q == OP_PRRD) stat_rd <= sat_inc(stat_rd);
            else                 stat_wr <= sat_inc(stat_wr);
            if (hit_c) stat_hit  <= sat_inc(stat_hit);
            else       stat_miss <= sat_inc(stat_miss);
          end
`endif
        end
        S_UPDATE: begin
          if (d_wr_st) st_q[idx_c][d_way] <= d_st;
          if (d_touch) plru_q[idx_c]      <= d_plru;
        end
        S_CLEAR: begin
          plru_q[clr_idx_q] <= '0;
          for (int w = 0; w < WAYS; w++) st_q[clr_idx_q][WAY_W'(w)] <= ST_I;
          clr_idx_q <= clr_idx_q + IDX_W'(1);
        end
        S_RESP: begin
          resp_valid   <= 1'b1;
          resp_hit     <= d_hit;
          resp_way     <= d_way;
          resp_bus_op  <= d_bus;
          resp_snp_res <= d_snp;
          resp_wb      <= d_wb;
          resp_wb_tag  <= d_wb_tag;
          resp_state   <= d_st;
        end
        default: ;
      endcase
    end
  end

  // Tag array needs no reset: a tag is only meaningful while its state is not I
  always_ff @(posedge clk) begin
    if (state_q == S_UPDATE && d_wr_tag) tag_q[idx_c][d_way] <= tag_c;
  end

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Self-checking bench for mesi_cache_ctrl with a small geometry (4 ways, 16 sets)
// so that random traffic exercises hits, evictions and writebacks.
module tb_mesi_cache_ctrl;

  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 64;
  localparam int WAYS       = 4;
  localparam int SETS       = 16;
  localparam int TAG_W      = 22;
  localparam int WAY_W      = 2;

  localparam int ST_M = 0;
  localparam int ST_E = 1;
  localparam int ST_S = 2;
  localparam int ST_I = 3;

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic [2:0]       bus;
    logic [1:0]       snp;
    logic             wb;
    logic [TAG_W-1:0] wbtag;
    logic [1:0]       st;
  } resp_t;

  logic              clk, rst_n;
  logic              req_valid, req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_snp_in;
  logic              resp_valid, resp_hit, resp_wb;
  logic [WAY_W-1:0]  resp_way;
  logic [2:0]        resp_bus_op;
  logic [1:0]        resp_snp_res, resp_state;
  logic [TAG_W-1:0]  resp_wb_tag;
`ifdef CACHE_STATS_EN
  logic [31:0]       stat_rd, stat_wr, stat_hit, stat_miss;
`endif

  int    checks = 0;
  int    errors = 0;
  resp_t r_got;

  mesi_cache_ctrl #(
    .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .WAYS(WAYS), .SETS(SETS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_snp_in(req_snp_in),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_bus_op(resp_bus_op), .resp_snp_res(resp_snp_res), .resp_wb(resp_wb),
    .resp_wb_tag(resp_wb_tag), .resp_state(resp_state)
`ifdef CACHE_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_hit(stat_hit), .stat_miss(stat_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-line tag/state, per-set PLRU node bits (1 = upper half used last)
  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  int               m_st  [SETS][WAYS];
  bit               m_up  [SETS][WAYS];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_st[s][w] = ST_I;
        m_up[s][w] = 1'b0;
      end
  endtask

  task automatic model_touch(input int s, input int w);
    int lo, hi, n, mid;
    bit up;
    lo = 0; hi = WAYS; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      up  = (w >= mid);
      m_up[s][n] = up;
      n = 2 * n + 1 + (up ? 1 : 0);
      if (up) lo = mid; else hi = mid;
    end
  endtask

  function automatic int model_victim(input int s);
    int lo, hi, n, mid;
    bit up;
    lo = 0; hi = WAYS; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      up  = !m_up[s][n];
      n = 2 * n + 1 + (up ? 1 : 0);
      if (up) lo = mid; else hi = mid;
    end
    return lo;
  endfunction

  task automatic model_step(input int op, input logic [31:0] addr, input int snp, output resp_t e);
    int s, hw, v, cur;
    logic [TAG_W-1:0] t;
    s  = int'(addr[9:6]);
    t  = addr[31:10];
    e  = '0;
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && m_st[s][w] != ST_I && m_tag[s][w] == t) hw = w;
    if (op == 0 || op == 1) begin
      if (hw >= 0) begin
        e.hit = 1'b1;
        v = hw;
        if (op == 1) begin
          if (m_st[s][v] == ST_S) e.bus = 3'd3;
          m_st[s][v] = ST_M;
        end
      end else begin
        v = -1;
        for (int w = 0; w < WAYS; w++) if (v < 0 && m_st[s][w] == ST_I) v = w;
        if (v < 0) v = model_victim(s);
        if (m_st[s][v] == ST_M) begin
          e.wb    = 1'b1;
          e.wbtag = m_tag[s][v];
        end
        m_tag[s][v] = t;
        if (op == 0) begin
          e.bus = 3'd1;
          m_st[s][v] = (snp == 0) ? ST_E : ST_S;
        end else begin
          e.bus = 3'd4;
          m_st[s][v] = ST_M;
        end
      end
      e.way = WAY_W'(v);
      e.st  = 2'(m_st[s][v]);
      model_touch(s, v);
    end else if (hw < 0) begin
      e.st = 2'(ST_I);
    end else begin
      e.hit = 1'b1;
      e.way = WAY_W'(hw);
      cur   = m_st[s][hw];
      case (op)
        2: begin
          if (cur == ST_M) begin
            e.snp = 2'd2; e.wb = 1'b1; e.wbtag = m_tag[s][hw]; m_st[s][hw] = ST_S;
          end else begin
            e.snp = 2'd1; m_st[s][hw] = ST_S;
          end
        end
        4: begin
          e.snp = (cur == ST_M) ? 2'd2 : 2'd1;
          if (cur == ST_M) begin e.wb = 1'b1; e.wbtag = m_tag[s][hw]; end
          m_st[s][hw] = ST_I;
        end
        5: if (cur == ST_S) begin e.snp = 2'd1; m_st[s][hw] = ST_I; end
        default: ;
      endcase
      e.st = 2'(m_st[s][hw]);
    end
  endtask

  // Issue one request and wait (bounded) for its response; lat = -1 on timeout
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] snp,
                      input int limit, output int lat, output bit ready_bad);
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_snp_in = snp;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_snp_in = 2'($urandom_range(0, 3));
    lat        = -1;
    ready_bad  = (req_ready !== 1'b0);
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk);
      #1;
      if (resp_valid === 1'b1) begin
        lat   = n;
        r_got = {resp_hit, resp_way, resp_bus_op, resp_snp_res, resp_wb, resp_wb_tag, resp_state};
        if (req_ready !== 1'b1) ready_bad = 1'b1;
        break;
      end else if (req_ready !== 1'b0) begin
        ready_bad = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    resp_t z;
    z = {resp_hit, resp_way, resp_bus_op, resp_snp_res, resp_wb, resp_wb_tag, resp_state};
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake ready=%b valid=%b want ready=1 valid=0", req_ready, resp_valid);
    end
    checks++;
    if (z !== resp_t'(0)) begin
      errors++;
      $display("FAIL reset_resp got %h want 0", z);
    end
  endtask

  task automatic test_basic();
    int lat; bit rb; resp_t e, m;
    logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd4};
    resp_t exp_tab [5];
    exp_tab[0] = {1'b0, 2'd0, 3'd1, 2'd0, 1'b0, 22'd0, 2'd1};
    exp_tab[1] = {1'b1, 2'd0, 3'd0, 2'd0, 1'b0, 22'd0, 2'd0};
    exp_tab[2] = {1'b1, 2'd0, 3'd0, 2'd2, 1'b1, 22'd0, 2'd2};
    exp_tab[3] = {1'b1, 2'd0, 3'd3, 2'd0, 1'b0, 22'd0, 2'd0};
    exp_tab[4] = {1'b1, 2'd0, 3'd0, 2'd2, 1'b1, 22'd0, 2'd3};
    for (int i = 0; i < 5; i++) begin
      send(ops[i], 32'h0000_0040, 2'd0, 10, lat, rb);
      model_step(int'(ops[i]), 32'h0000_0040, 0, m);
      e = exp_tab[i];
      checks++;
      if (lat !== 3 || rb) begin
        errors++;
        $display("FAIL basic_latency step %0d got lat=%0d ready_bad=%0d want lat=3 ready_bad=0", i, lat, rb);
      end
      checks++;
      if (r_got !== e) begin
        errors++;
        $display("FAIL basic_resp step %0d got %h want %h", i, r_got, e);
      end
    end
  endtask

  task automatic test_evict();
    int lat; bit rb; resp_t e, lit;
    logic [31:0] a;
    lit = {1'b0, 2'd0, 3'd4, 2'd0, 1'b1, 22'd1, 2'd0};
    for (int t = 1; t <= WAYS + 1; t++) begin
      a = (32'(t) << 10) | 32'h0000_0080;
      send(3'd1, a, 2'd0, 10, lat, rb);
      model_step(1, a, 0, e);
      checks++;
      if (r_got !== e || lat !== 3) begin
        errors++;
        $display("FAIL evict_fill tag %0d got %h lat=%0d want %h lat=3", t, r_got, lat, e);
      end
    end
    checks++;
    if (r_got !== lit) begin
      errors++;
      $display("FAIL evict_victim got %h want %h", r_got, lit);
    end
  endtask

  task automatic test_random();
    int lat; bit rb; resp_t e;
    int op, snp;
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      op  = $urandom_range(0, 5);
      snp = $urandom_range(0, 3);
      a   = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 63));
      send(3'(op), a, 2'(snp), 10, lat, rb);
      model_step(op, a, snp, e);
      checks++;
      if (r_got !== e || lat !== 3 || rb) begin
        errors++;
        $display("FAIL random #%0d op=%0d addr=%h snp=%0d got %h lat=%0d rb=%0d want %h lat=3",
                 i, op, a, snp, r_got, lat, rb, e);
      end
    end
  endtask

  task automatic test_clear();
    int lat; bit rb; resp_t e;
    logic [31:0] a;
    send(3'd7, 32'h0000_0000, 2'd0, SETS + 20, lat, rb);
    model_reset();
    checks++;
    if (lat !== SETS + 1 || rb) begin
      errors++;
      $display("FAIL clear_latency got lat=%0d ready_bad=%0d want lat=%0d ready_bad=0", lat, rb, SETS + 1);
    end
    for (int i = 0; i < 8; i++) begin
      a = (32'($urandom_range(0, 7)) << 10) | (32'(i) << 6);
      send(3'd0, a, 2'($urandom_range(0, 3)), 10, lat, rb);
      model_step(0, a, int'(req_snp_in), e);
      e.st = (e.st == 2'(ST_E) || e.st == 2'(ST_S)) ? e.st : e.st;
      checks++;
      if (r_got.hit !== 1'b0 || r_got.bus !== 3'd1 || lat !== 3) begin
        errors++;
        $display("FAIL clear_miss #%0d got hit=%b bus=%0d lat=%0d want hit=0 bus=1 lat=3",
                 i, r_got.hit, r_got.bus, lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit rb; resp_t e, z;
    bit seen;
    send(3'd0, 32'h0012_3400, 2'd0, 10, lat, rb);
    model_step(0, 32'h0012_3400, 0, e);
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = 3'd1;
    req_addr   = 32'h0012_3400;
    req_snp_in = 2'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    z = {resp_hit, resp_way, resp_bus_op, resp_snp_res, resp_wb, resp_wb_tag, resp_state};
    checks++;
    if (resp_valid !== 1'b0 || z !== resp_t'(0)) begin
      errors++;
      $display("FAIL reset_mid_outputs got valid=%b resp=%h want valid=0 resp=0", resp_valid, z);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_noresp got resp_valid=1 want no response");
    end
    model_reset();
    send(3'd0, 32'h0012_3400, 2'd0, 10, lat, rb);
    model_step(0, 32'h0012_3400, 0, e);
    checks++;
    if (r_got !== e || lat !== 3) begin
      errors++;
      $display("FAIL reset_mid_after got %h lat=%0d want %h lat=3", r_got, lat, e);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_addr   = '0;
    req_snp_in = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_evict();
    test_random();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
